// File: rtl/elevator_pkg.sv
// Shared sizing defaults and request/floor types for the elevator front end.
package elevator_pkg;

  localparam int FLOOR_NUMBERS   = 10;
  localparam int FLOOR_W         = 4;
  localparam int DEBOUNCE_CYCLES = 4;

  typedef logic [FLOOR_W-1:0]       floor_t;
  typedef logic [FLOOR_NUMBERS-1:0] req_vec_t;

endpackage

// File: rtl/call_request_latch_debounce_cell.sv
// One push-button bit: 2-flop synchronizer, stability counter and debounced level.
// rise is combinational and fires in the cycle whose closing edge raises level.
module debounce_cell
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES_P = DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES_P + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES_P - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic [CW-1:0] count_reg;
  logic          flip;

  // The counter only advances while the synchronized input disagrees with level.
  assign flip = (sync2_reg != level_reg) && (count_reg == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg == level_reg) begin
        count_reg <= '0;
      end else if (flip) begin
        count_reg <= '0;
        level_reg <= ~level_reg;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;
  assign rise  = flip & ~level_reg;

endmodule

// File: rtl/call_request_latch.sv
// Debounces hall/cabin buttons and latches presses as pending requests, cleared on door open.
// Optional macro CALL_CANCEL_EN: re-pressing a pending cabin button cancels it.
module call_request_latch
  import elevator_pkg::*;
#(
  parameter int FLOOR_NUMBERS_P   = FLOOR_NUMBERS,
  parameter int FLOOR_W_P         = FLOOR_W,
  parameter int DEBOUNCE_CYCLES_P = DEBOUNCE_CYCLES
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [FLOOR_NUMBERS_P-1:0] raw_buttons,
  input  logic [FLOOR_NUMBERS_P-1:0] raw_ups,
  input  logic [FLOOR_NUMBERS_P-1:0] raw_downs,
  input  logic                       open,
  input  logic [FLOOR_W_P-1:0]       floor,
  output logic [FLOOR_NUMBERS_P-1:0] buttons,
  output logic [FLOOR_NUMBERS_P-1:0] ups,
  output logic [FLOOR_NUMBERS_P-1:0] downs,
  output logic                       any_pending
);

  localparam int N = FLOOR_NUMBERS_P;
  // No up-call from the top floor, no down-call from the bottom floor.
  localparam logic [N-1:0] UP_MASK = ~(N'(1) << (N - 1));
  localparam logic [N-1:0] DN_MASK = ~N'(1);

  logic [N-1:0] btn_rise, up_rise, dn_rise;
  logic [N-1:0] btn_level, up_level, dn_level;
  logic [N-1:0] clr;
  logic [N-1:0] buttons_reg, ups_reg, downs_reg;
  logic [N-1:0] buttons_next, ups_next, downs_next;
  logic         any_reg, any_next;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_floor
      debounce_cell #(.DEBOUNCE_CYCLES_P(DEBOUNCE_CYCLES_P)) u_btn (
        .clock(clock), .reset(reset), .raw(raw_buttons[gi]),
        .level(btn_level[gi]), .rise(btn_rise[gi]));
      debounce_cell #(.DEBOUNCE_CYCLES_P(DEBOUNCE_CYCLES_P)) u_up (
        .clock(clock), .reset(reset), .raw(raw_ups[gi]),
        .level(up_level[gi]), .rise(up_rise[gi]));
      debounce_cell #(.DEBOUNCE_CYCLES_P(DEBOUNCE_CYCLES_P)) u_dn (
        .clock(clock), .reset(reset), .raw(raw_downs[gi]),
        .level(dn_level[gi]), .rise(dn_rise[gi]));
      // Out-of-range floor codes never match any index, so they clear nothing.
      assign clr[gi] = open && (floor == FLOOR_W_P'(gi));
    end
  endgenerate

  always_comb begin
    buttons_next = buttons_reg;
    ups_next     = ups_reg;
    downs_next   = downs_reg;
`ifdef CALL_CANCEL_EN
    buttons_next = (buttons_reg ^ btn_rise) & ~clr;
`else
    buttons_next = (buttons_reg | btn_rise) & ~clr;
`endif
    ups_next     = (ups_reg | up_rise) & UP_MASK & ~clr;
    downs_next   = (downs_reg | dn_rise) & DN_MASK & ~clr;
    any_next     = |{buttons_next, ups_next, downs_next};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buttons_reg <= '0;
      ups_reg     <= '0;
      downs_reg   <= '0;
      any_reg     <= 1'b0;
    end else begin
      buttons_reg <= buttons_next;
      ups_reg     <= ups_next;
      downs_reg   <= downs_next;
      any_reg     <= any_next;
    end
  end

  assign buttons     = buttons_reg;
  assign ups         = ups_reg;
  assign downs       = downs_reg;
  assign any_pending = any_reg;

endmodule

// File: tb/tb_call_request_latch.sv
// Scoreboard bench for call_request_latch: stimulus queues expected outputs, a monitor compares them.
module tb_call_request_latch;
  import elevator_pkg::*;

  localparam int N = FLOOR_NUMBERS;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [N-1:0]       raw_buttons = '0;
  logic [N-1:0]       raw_ups = '0;
  logic [N-1:0]       raw_downs = '0;
  logic               open = 1'b0;
  logic [FLOOR_W-1:0] floor = '0;
  logic [N-1:0]       buttons, ups, downs;
  logic               any_pending;

  typedef struct packed {
    logic [N-1:0] b;
    logic [N-1:0] u;
    logic [N-1:0] d;
    logic         ap;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  call_request_latch dut (
    .clock(clock), .reset(reset),
    .raw_buttons(raw_buttons), .raw_ups(raw_ups), .raw_downs(raw_downs),
    .open(open), .floor(floor),
    .buttons(buttons), .ups(ups), .downs(downs), .any_pending(any_pending)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_out(input string nm, input logic [N-1:0] b, input logic [N-1:0] u,
                            input logic [N-1:0] d);
    exp_t e;
    e.b  = b;
    e.u  = u;
    e.d  = d;
    e.ap = |{b, u, d};
    name_q.push_back(nm);
    exp_q.push_back(e);
  endtask

  task automatic service(input int f);
    open  = 1'b1;
    floor = FLOOR_W'(f);
    tick(1);
    open  = 1'b0;
  endtask

  // Monitor: pops each queued expectation and compares against the live outputs.
  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      wait (exp_q.size() != 0);
      nm = name_q.pop_front();
      e  = exp_q.pop_front();
      checks++;
      if ({buttons, ups, downs, any_pending} !== e) begin
        errors++;
        $display("FAIL %s: got b=%h u=%h d=%h ap=%b, want b=%h u=%h d=%h ap=%b", nm,
                 buttons, ups, downs, any_pending, e.b, e.u, e.d, e.ap);
      end else begin
        $display("ok   %s: b=%h u=%h d=%h ap=%b", nm, buttons, ups, downs, any_pending);
      end
    end
  end

  initial begin : stimulus
    tick(2);
    expect_out("reset_state", 10'h000, 10'h000, 10'h000);
    reset = 1'b0;

    // Clean press: latched after edge 5, not before, and held after release.
    raw_ups[3] = 1'b1;
    tick(5);
    expect_out("press_before_latency", 10'h000, 10'h000, 10'h000);
    tick(1);
    expect_out("press_at_latency", 10'h000, 10'h008, 10'h000);
    raw_ups[3] = 1'b0;
    tick(10);
    expect_out("press_held_after_release", 10'h000, 10'h008, 10'h000);

    // Bounce: runs of 3 never reach the 4-cycle threshold.
    raw_buttons[7] = 1'b1; tick(3);
    raw_buttons[7] = 1'b0; tick(1);
    raw_buttons[7] = 1'b1; tick(3);
    raw_buttons[7] = 1'b0; tick(8);
    expect_out("bounce_rejected", 10'h000, 10'h008, 10'h000);
    raw_buttons[7] = 1'b1;
    tick(5);
    expect_out("stable_before_latency", 10'h000, 10'h008, 10'h000);
    tick(1);
    expect_out("stable_at_latency", 10'h080, 10'h008, 10'h000);
    raw_buttons[7] = 1'b0;
    tick(8);

    // Service clear at floor 2.
    raw_ups[2] = 1'b1; raw_buttons[2] = 1'b1; raw_downs[5] = 1'b1;
    tick(8);
    raw_ups[2] = 1'b0; raw_buttons[2] = 1'b0; raw_downs[5] = 1'b0;
    tick(8);
    expect_out("multi_pending", 10'h084, 10'h00C, 10'h020);
    service(2);
    expect_out("clear_floor2", 10'h080, 10'h008, 10'h020);
    service(7);
    expect_out("clear_floor7", 10'h000, 10'h008, 10'h020);
    service(3);
    expect_out("clear_floor3", 10'h000, 10'h000, 10'h020);
    service(12);
    expect_out("floor12_no_clear", 10'h000, 10'h000, 10'h020);
    floor = FLOOR_W'(5);
    tick(1);
    expect_out("closed_no_clear", 10'h000, 10'h000, 10'h020);
    service(5);
    expect_out("clear_floor5", 10'h000, 10'h000, 10'h000);

    // Invalid calls ignored.
    raw_ups[9] = 1'b1; raw_downs[0] = 1'b1;
    tick(10);
    expect_out("invalid_calls", 10'h000, 10'h000, 10'h000);
    raw_ups[9] = 1'b0; raw_downs[0] = 1'b0;
    tick(6);

    // Press completes on the same edge as door open at that floor: clear wins.
    raw_buttons[4] = 1'b1;
    tick(5);
    expect_out("collision_before", 10'h000, 10'h000, 10'h000);
    service(4);
    expect_out("collision_clear_wins", 10'h000, 10'h000, 10'h000);
    tick(5);
    expect_out("held_sets_once", 10'h000, 10'h000, 10'h000);
    raw_buttons[4] = 1'b0;
    tick(8);

    // Second press of a pending cabin button.
    raw_buttons[6] = 1'b1; tick(8);
    raw_buttons[6] = 1'b0; tick(8);
    expect_out("first_press6", 10'h040, 10'h000, 10'h000);
    raw_buttons[6] = 1'b1; tick(8);
    raw_buttons[6] = 1'b0; tick(8);
`ifdef CALL_CANCEL_EN
    expect_out("second_press6", 10'h000, 10'h000, 10'h000);
`else
    expect_out("second_press6", 10'h040, 10'h000, 10'h000);
`endif
    service(6);
    expect_out("clear_floor6", 10'h000, 10'h000, 10'h000);

    // Reset with 0x205 pending and ups[1] mid-debounce.
    raw_buttons = 10'h205; tick(8);
    raw_buttons = 10'h000; tick(8);
    expect_out("pending_205", 10'h205, 10'h000, 10'h000);
    raw_ups[1] = 1'b1;
    tick(2);
    #2 reset = 1'b1;
    #1 expect_out("async_reset", 10'h000, 10'h000, 10'h000);
    @(negedge clock);
    reset = 1'b0;
    tick(5);
    expect_out("redetect_before", 10'h000, 10'h000, 10'h000);
    tick(1);
    expect_out("redetect_at_latency", 10'h000, 10'h002, 10'h000);
    raw_ups[1] = 1'b0;
    tick(4);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
